ball_engine: RTL and testbench



---
 rtl/ball_engine.sv | 167 ++++++++++++++++
 tb/tb_ball_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Ball engine: owns ball position and direction, steps the ball at a fixed tick
// rate, reflects off walls and paddles, and reports misses as one-cycle score pulses.
module ball_engine #(
  parameter int X_RESOLUTION         = 640,
  parameter int Y_RESOLUTION         = 480,
  parameter int BALL_TICKS_PER_PIXEL = 200000,
  parameter int SERVE_DELAY_TICKS    = 50000000,
  parameter int LEFT_PADDLE_X        = 16,
  parameter int RIGHT_PADDLE_X       = 623,
  parameter int PADDLE_HALF_HEIGHT   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_on,
  input  logic signed [31:0] left_pos,
  input  logic signed [31:0] right_pos,
  output logic signed [31:0] ball_x,
  output logic signed [31:0] ball_y,
  output logic               ball_active,
  output logic               left_scored,
  output logic               right_scored,
  output logic [1:0]         debug_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    SCORED     = 2'd3
  } state_t;

  localparam logic signed [31:0] X_CENTRE   = 32'(X_RESOLUTION / 2);
  localparam logic signed [31:0] Y_CENTRE   = 32'(Y_RESOLUTION / 2);
  localparam logic signed [31:0] X_MAX      = 32'(X_RESOLUTION - 1);
  localparam logic signed [31:0] Y_MAX      = 32'(Y_RESOLUTION - 1);
  localparam logic signed [31:0] LEFT_X     = 32'(LEFT_PADDLE_X);
  localparam logic signed [31:0] RIGHT_X    = 32'(RIGHT_PADDLE_X);
  localparam logic signed [32:0] HALF       = 33'(PADDLE_HALF_HEIGHT);
  localparam logic [31:0]        TICK_LAST  = 32'(BALL_TICKS_PER_PIXEL - 1);
  localparam logic [31:0]        SERVE_LAST = 32'(SERVE_DELAY_TICKS - 1);

  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d, y_q, y_d;
  logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic               side_left_q, side_left_d;
  logic [31:0]        tick_q, tick_d, serve_q, serve_d;

  logic signed [31:0] nx, ny;
  logic signed [32:0] diff_l, diff_r;
  logic               hit_l, hit_r;

  assign nx = x_q + (dx_neg_q ? -32'sd1 : 32'sd1);
  assign ny = y_q + (dy_neg_q ? -32'sd1 : 32'sd1);

  // One extra bit so arbitrary out-of-range paddle values cannot wrap the distance.
  assign diff_l = {y_q[31], y_q} - {left_pos[31], left_pos};
  assign diff_r = {y_q[31], y_q} - {right_pos[31], right_pos};
  assign hit_l  = dx_neg_q && (nx <= LEFT_X) && (x_q > LEFT_X)
                  && (diff_l <= HALF) && (diff_l >= -HALF);
  assign hit_r  = !dx_neg_q && (nx >= RIGHT_X) && (x_q < RIGHT_X)
                  && (diff_r <= HALF) && (diff_r >= -HALF);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    side_left_d = side_left_q;
    tick_d      = tick_q;
    serve_d     = serve_q;
    if (!game_on) begin
      state_d = IDLE;
      x_d     = X_CENTRE;
      y_d     = Y_CENTRE;
      tick_d  = '0;
      serve_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          serve_d = SERVE_LAST;
          state_d = SERVE_WAIT;
        end
        SERVE_WAIT: begin
          if (serve_q == '0) begin
            tick_d  = '0;
            state_d = PLAY;
          end else begin
            serve_d = serve_q - 32'd1;
          end
        end
        PLAY: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (ny < 0) begin
              dy_neg_d = 1'b0;
              y_d      = '0;
            end else if (ny > Y_MAX) begin
              dy_neg_d = 1'b1;
              y_d      = Y_MAX;
            end else begin
              y_d = ny;
            end
            // Paddle hits take priority over misses.
            if (hit_l) begin
              x_d      = LEFT_X;
              dx_neg_d = 1'b0;
            end else if (hit_r) begin
              x_d      = RIGHT_X;
              dx_neg_d = 1'b1;
            end else if (nx < 0) begin
              side_left_d = 1'b0;
              dx_neg_d    = 1'b1;
              state_d     = SCORED;
            end else if (nx > X_MAX) begin
              side_left_d = 1'b1;
              dx_neg_d    = 1'b0;
              state_d     = SCORED;
            end else begin
              x_d = nx;
            end
          end else begin
            tick_d = tick_q + 32'd1;
          end
        end
        SCORED: begin
          x_d      = X_CENTRE;
          y_d      = Y_CENTRE;
          dy_neg_d = 1'b0;
          serve_d  = SERVE_LAST;
          state_d  = SERVE_WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= X_CENTRE;
      y_q         <= Y_CENTRE;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      side_left_q <= 1'b0;
      tick_q      <= '0;
      serve_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      side_left_q <= side_left_d;
      tick_q      <= tick_d;
      serve_q     <= serve_d;
    end
  end

  assign ball_x       = x_q;
  assign ball_y       = y_q;
  assign ball_active  = (state_q == PLAY);
  assign left_scored  = (state_q == SCORED) && side_left_q;
  assign right_scored = (state_q == SCORED) && !side_left_q;
  assign debug_state  = state_q;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: a cycle-level reference model predicts every output,
// plus directed checks on serve timing, bounces, misses, abort and async reset.
module tb_ball_engine;

  localparam int XR  = 32;
  localparam int YR  = 16;
  localparam int TPP = 2;
  localparam int SD  = 4;
  localparam int LPX = 2;
  localparam int RPX = 29;
  localparam int HH  = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               game_on = 1'b0;
  logic signed [31:0] left_pos = '0;
  logic signed [31:0] right_pos = '0;
  logic signed [31:0] ball_x, ball_y;
  logic               ball_active, left_scored, right_scored;
  logic [1:0]         debug_state;

  always #5 clk = ~clk;

  ball_engine #(
    .X_RESOLUTION(XR), .Y_RESOLUTION(YR), .BALL_TICKS_PER_PIXEL(TPP),
    .SERVE_DELAY_TICKS(SD), .LEFT_PADDLE_X(LPX), .RIGHT_PADDLE_X(RPX),
    .PADDLE_HALF_HEIGHT(HH)
  ) dut (
    .clk(clk), .reset(reset), .game_on(game_on),
    .left_pos(left_pos), .right_pos(right_pos),
    .ball_x(ball_x), .ball_y(ball_y), .ball_active(ball_active),
    .left_scored(left_scored), .right_scored(right_scored),
    .debug_state(debug_state)
  );

  int checks = 0;
  int errors = 0;
  logic [68:0] exp_q[$];

  // Reference model state: 0 idle, 1 serve wait, 2 play, 3 scored.
  int m_state, m_x, m_y, m_dx, m_dy, m_tick, m_serve, m_steps;
  bit m_side_left;
  int l_off = 0;
  int r_off = 0;

  task automatic check_vec(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [68:0] model_out();
    return {32'(m_x), 32'(m_y), m_state == 2, (m_state == 3) && m_side_left,
            (m_state == 3) && !m_side_left, 2'(m_state)};
  endfunction

  function automatic logic [68:0] dut_out();
    return {ball_x, ball_y, ball_active, left_scored, right_scored, debug_state};
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = XR / 2; m_y = YR / 2; m_dx = 1; m_dy = 1;
    m_tick = 0; m_serve = 0; m_side_left = 1'b0;
  endtask

  task automatic model_step();
    longint dl, dr;
    int nx, ny;
    bit hl, hr;
    nx = m_x + m_dx;
    ny = m_y + m_dy;
    dl = longint'(m_y) - longint'(left_pos);
    dr = longint'(m_y) - longint'(right_pos);
    if (dl < 0) dl = -dl;
    if (dr < 0) dr = -dr;
    hl = (m_dx < 0) && (nx <= LPX) && (m_x > LPX) && (dl <= HH);
    hr = (m_dx > 0) && (nx >= RPX) && (m_x < RPX) && (dr <= HH);
    if (ny < 0) begin m_dy = 1; m_y = 0; end
    else if (ny > YR - 1) begin m_dy = -1; m_y = YR - 1; end
    else m_y = ny;
    if (hl) begin m_x = LPX; m_dx = 1; end
    else if (hr) begin m_x = RPX; m_dx = -1; end
    else if (nx < 0) begin m_side_left = 1'b0; m_dx = -1; m_state = 3; end
    else if (nx > XR - 1) begin m_side_left = 1'b1; m_dx = 1; m_state = 3; end
    else m_x = nx;
    m_steps++;
  endtask

  task automatic model_edge();
    if (!game_on) begin
      m_state = 0; m_x = XR / 2; m_y = YR / 2; m_tick = 0; m_serve = 0;
    end else begin
      case (m_state)
        0: begin m_serve = SD - 1; m_state = 1; end
        1: begin
          if (m_serve == 0) begin m_tick = 0; m_state = 2; end
          else m_serve--;
        end
        2: begin
          if (m_tick == TPP - 1) begin m_tick = 0; model_step(); end
          else m_tick++;
        end
        default: begin
          m_x = XR / 2; m_y = YR / 2; m_dy = 1; m_serve = SD - 1; m_state = 1;
        end
      endcase
    end
  endtask

  // Drive paddles from the model, predict the next cycle, clock, then compare.
  task automatic tick();
    logic [68:0] exp;
    left_pos  = 32'(m_y + l_off);
    right_pos = 32'(m_y + r_off);
    model_edge();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_vec("cycle", dut_out(), exp);
  endtask

  task automatic run_steps(input int n, input int budget);
    int target;
    target = m_steps + n;
    for (int c = 0; c < budget && m_steps < target; c++) tick();
    check_int("step_budget", m_steps, target);
  endtask

  task automatic run_until_scored(input int budget);
    for (int c = 0; c < budget && m_state != 3; c++) tick();
    check_int("scored_state", debug_state, 3);
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check_int({tag, "_x"}, ball_x, x);
    check_int({tag, "_y"}, ball_y, y);
  endtask

  initial begin
    m_steps = 0;
    model_reset();
    #12;
    check_pos("reset", 16, 8);
    check_int("reset_active", ball_active, 0);
    check_int("reset_ls", left_scored, 0);
    check_int("reset_rs", right_scored, 0);
    check_int("reset_state", debug_state, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Serve timing with both paddles tracking the ball at the window edge.
    l_off = -2;
    r_off = 2;
    tick();
    check_int("idle_hold", debug_state, 0);
    game_on = 1'b1;
    repeat (4) tick();
    check_int("serve_wait_state", debug_state, 1);
    check_int("serve_wait_active", ball_active, 0);
    check_pos("serve_wait", 16, 8);
    tick();
    check_int("play_active", ball_active, 1);
    check_pos("play_start", 16, 8);
    tick();
    check_pos("pre_step", 16, 8);
    tick();
    check_pos("first_step", 17, 9);
    tick();
    check_pos("between_steps", 17, 9);
    tick();
    check_pos("second_step", 18, 10);

    // Wall bounce at y=0, then left paddle corner hit at the bottom wall.
    run_steps(22, 200);
    check_pos("top_wall", 18, 0);
    run_steps(1, 20);
    check_pos("top_bounce", 17, 1);
    run_steps(15, 200);
    check_pos("corner_hit", 2, 15);
    run_steps(1, 20);
    check_pos("corner_after", 3, 14);

    // Left paddle just outside its window: right player scores.
    l_off = 3;
    run_until_scored(600);
    check_int("miss_rs", right_scored, 1);
    check_int("miss_ls", left_scored, 0);
    tick();
    check_int("rs_one_cycle", right_scored, 0);
    check_pos("recentre", 16, 8);
    check_int("reserve_state", debug_state, 1);
    run_steps(1, 40);
    check_pos("serve_left", 15, 9);

    // Right paddle misses: left player scores, serve goes rightward.
    l_off = 0;
    r_off = 3;
    run_until_scored(600);
    check_int("miss2_ls", left_scored, 1);
    check_int("miss2_rs", right_scored, 0);
    tick();
    check_int("ls_one_cycle", left_scored, 0);
    run_steps(1, 40);
    check_pos("serve_right", 17, 9);

    // Abort mid-PLAY between steps.
    run_steps(3, 40);
    check_pos("pre_abort", 20, 12);
    tick();
    game_on = 1'b0;
    tick();
    check_int("abort_state", debug_state, 0);
    check_int("abort_active", ball_active, 0);
    check_int("abort_pulse", {left_scored, right_scored}, 0);
    check_pos("abort", 16, 8);
    tick();
    game_on = 1'b1;
    run_steps(2, 40);
    check_pos("resume", 18, 10);

    // Asynchronous reset between clock edges.
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_pos("async_reset", 16, 8);
    check_int("async_active", ball_active, 0);
    check_int("async_state", debug_state, 0);
    check_int("async_pulse", {left_scored, right_scored}, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_steps(1, 40);
    check_pos("after_reset_step", 17, 9);

    check_int("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
